// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite encodings used by the AHB slaves in this MCU, plus the
//   state encoding of the byte-serialising SRAM bridge (ahb_sram8_bridge).
//   No ports: this is a package only.
// ----------------------------------------------------------------------------
package ahb_pkg;

    // Transfer type (htrans)
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Transfer size (hsize)
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Slave response (hresp)
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE,     // no data phase in progress
        ST_WR,       // issuing one SRAM byte write per cycle
        ST_RD,       // issuing one SRAM byte read per cycle
        ST_RD_LAST,  // capturing the final read byte, transfer completes
        ST_ERR1,     // first ERROR cycle (hreadyout low)
        ST_ERR2      // second ERROR cycle (hreadyout high)
    } bridge_state_e;

endpackage

// File: rtl/ahb_sram8_bridge.sv
// ----------------------------------------------------------------------------
// ahb_sram8_bridge
//   AHB-Lite slave in front of the byte-wide 2 KB single-port SRAM wrapper.
//   Each 8/16/32-bit AHB transfer is serialised into one SRAM byte access per
//   cycle; wait states are inserted until the last byte is done.  Misaligned
//   or oversized transfers get a two-cycle ERROR with no SRAM access.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   hsel .. hready       AHB-Lite address/data phase inputs
//   hreadyout, hresp     slave ready and response
//   hrdata               read data (little-endian byte lanes)
//   sram_cs / sram_wen   SRAM chip select (high) / write enable (low)
//   sram_addr/sram_data  SRAM byte address and write data
//   sram_q               SRAM read data, valid one cycle after a read access
// ----------------------------------------------------------------------------
module ahb_sram8_bridge
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int HDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   hsel,
    input  logic [31:0]            haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [HDATA_WIDTH-1:0] hwdata,
    input  logic                   hready,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [HDATA_WIDTH-1:0] hrdata,
    output logic                   sram_cs,
    output logic                   sram_wen,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [7:0]             sram_data,
    input  logic [7:0]             sram_q
);

    bridge_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [1:0]                k_q, k_d;        // byte counter within the transfer
    logic [1:0]                last_q, last_d;  // N-1
    logic [HDATA_WIDTH-1:0]    hrdata_q, hrdata_d;

    logic                  accept;
    logic                  req_err;
    logic                  done;
    logic [ADDR_WIDTH-1:0] byte_addr;
    logic [1:0]            lane;
    logic [1:0]            lane_prev;
    logic                  unused_bits;

    assign accept  = hsel & htrans[1] & hready;
    assign req_err = (hsize > HSIZE_WORD)
                   | ((hsize == HSIZE_HALF) & haddr[0])
                   | ((hsize == HSIZE_WORD) & (haddr[1:0] != 2'b00));

    // Addresses wrap modulo 2^ADDR_WIDTH; the lane follows the wrapped address.
    assign byte_addr = base_q + ADDR_WIDTH'(k_q);
    assign lane      = byte_addr[1:0];
    // Lane of the read issued one cycle earlier, whose data is on sram_q now.
    assign lane_prev = lane - 2'd1;

    assign unused_bits = ^{haddr[31:ADDR_WIDTH], htrans[0]};

    // SRAM address is decoded from registered state only, never from haddr.
    assign sram_addr = byte_addr;

    // The final read byte comes straight from sram_q in the completing
    // cycle, so hrdata shows the next-state value rather than the flop.
    assign hrdata = hrdata_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        base_d    = base_q;
        k_d       = k_q;
        last_d    = last_q;
        hrdata_d  = hrdata_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        sram_cs   = 1'b0;
        sram_wen  = 1'b1;
        sram_data = 8'h00;
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: done = 1'b1;
            ST_WR: begin
                sram_cs   = 1'b1;
                sram_wen  = 1'b0;
                // AHB holds hwdata stable through wait states, so no copy is kept.
                sram_data = hwdata[{lane, 3'b000} +: 8];
                k_d       = k_q + 2'd1;
                if (k_q == last_q) done = 1'b1;
                else               hreadyout = 1'b0;
            end
            ST_RD: begin
                sram_cs   = 1'b1;
                hreadyout = 1'b0;
                k_d       = k_q + 2'd1;
                if (k_q != 2'd0) hrdata_d[{lane_prev, 3'b000} +: 8] = sram_q;
                if (k_q == last_q) state_d = ST_RD_LAST;
            end
            ST_RD_LAST: begin
                hrdata_d[{lane_prev, 3'b000} +: 8] = sram_q;
                done = 1'b1;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
                done  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new address phase is only taken in a cycle that ends a data phase
        // (or in IDLE); it is decoded here and starts issuing next cycle.
        if (done) begin
            if (accept) begin
                base_d = haddr[ADDR_WIDTH-1:0];
                k_d    = 2'd0;
                unique case (hsize)
                    HSIZE_HALF: last_d = 2'd1;
                    HSIZE_WORD: last_d = 2'd3;
                    default:    last_d = 2'd0;
                endcase
                if (req_err)     state_d = ST_ERR1;
                else if (hwrite) state_d = ST_WR;
                else             state_d = ST_RD;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            k_q      <= 2'd0;
            last_q   <= 2'd0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            k_q      <= k_d;
            last_q   <= last_d;
            hrdata_q <= hrdata_d;
        end
    end

endmodule
